// File: rtl/jpeg_dec_pkg.sv
// Shared fp32 field layout and pixel-range constants for the JPEG decoder output path.
package jpeg_dec_pkg;
  localparam int FP32_SIGN_W = 1;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_MAN_W  = 23;

  localparam logic [FP32_EXP_W-1:0] FP32_BIAS    = 8'd127;
  localparam logic [FP32_EXP_W-1:0] FP32_EXP_MAX = 8'hFF;
  localparam logic [7:0]            LEVEL_OFFSET = 8'd128;
  localparam logic [7:0]            PIX_MAX      = 8'd255;

  typedef struct packed {
    logic [FP32_SIGN_W-1:0] s;
    logic [FP32_EXP_W-1:0]  e;
    logic [FP32_MAN_W-1:0]  m;
  } fp32_t;

  // Stage-1 classification carried into the rounding stage
  typedef enum logic [1:0] {CLS_ZERO, CLS_ROUND, CLS_SAT_POS, CLS_SAT_NEG} cls_e;
endpackage

// File: rtl/inverse_level_shift_if.sv
// Row bus between the float IDCT and the pixel writer: fp32 samples in, pixels out.
interface inverse_level_shift_if #(parameter int LANES = 8) ();
  logic [LANES-1:0][31:0] din;
  logic                   din_valid;
  logic [LANES-1:0][7:0]  dout;
  logic                   dout_valid;
  logic                   dout_last;

  modport slave  (input  din, din_valid, output dout, dout_valid, dout_last);
  modport master (output din, din_valid, input  dout, dout_valid, dout_last);
endinterface

// File: rtl/fp32_to_pixel.sv
// Single-lane fp32 -> level-shifted 8-bit pixel, 3 register stages, no valid tracking.
module fp32_to_pixel
  import jpeg_dec_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] i_din,
    output logic [7:0]  o_pix
);
    fp32_t       w_f;
    cls_e        w_cls;
    logic [4:0]  w_sh;
    cls_e        r_cls;
    logic        r_sign;
    logic [4:0]  r_sh;
    logic [23:0] r_sig;

    // Right-shift that leaves the integer part: 150 - E, valid for E in 126..134.
    // Only 5 bits are needed, so the subtraction is done mod 32.
    always_comb begin
        w_f   = fp32_t'(i_din);
        w_sh  = 5'(FP32_BIAS[4:0] + 5'd23) - w_f.e[4:0];
        w_cls = CLS_ROUND;
        if (w_f.e == '0)
            w_cls = CLS_ZERO;
        else if (w_f.e == FP32_EXP_MAX)
            w_cls = (w_f.m != '0) ? CLS_ZERO : (w_f.s[0] ? CLS_SAT_NEG : CLS_SAT_POS);
        else if (w_f.e >= FP32_BIAS + 8'd8)
            w_cls = w_f.s[0] ? CLS_SAT_NEG : CLS_SAT_POS;
        else if (w_f.e <= FP32_BIAS - 8'd2)
            w_cls = CLS_ZERO;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cls  <= CLS_ZERO;
            r_sign <= 1'b0;
            r_sh   <= '0;
            r_sig  <= '0;
        end else begin
            r_cls  <= w_cls;
            r_sign <= w_f.s[0];
            r_sh   <= w_sh;
            r_sig  <= {1'b1, w_f.m};
        end
    end

    logic [8:0]        w_q;
    logic [23:0]       w_mask;
    logic [7:0]        w_int;
    logic              w_grd, w_stk;
    logic [8:0]        w_mag;
    logic signed [9:0] w_val;
    logic signed [9:0] r_int;

    // Keep one extra bit below the integer as guard; everything under it is sticky
    always_comb begin
        w_q    = 9'(r_sig >> (r_sh - 5'd1));
        w_mask = (24'd1 << (r_sh - 5'd1)) - 24'd1;
        w_int  = w_q[8:1];
        w_grd  = w_q[0];
        w_stk  = |(r_sig & w_mask);
        w_mag  = {1'b0, w_int} + {8'd0, w_grd & (w_stk | w_int[0])};
        w_val  = '0;
        case (r_cls)
            CLS_ROUND:   w_val = r_sign ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
            CLS_SAT_POS: w_val = 10'sd256;
            CLS_SAT_NEG: w_val = -10'sd256;
            default:     w_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_int <= '0;
        else       r_int <= w_val;
    end

    logic signed [10:0] w_sum;
    logic [7:0]         w_pix;
    logic [7:0]         r_pix;

    always_comb begin
        w_sum = {r_int[9], r_int} + $signed({3'b000, LEVEL_OFFSET});
        if (w_sum[10])             w_pix = 8'd0;
        else if (w_sum[9:8] != '0) w_pix = PIX_MAX;
        else                       w_pix = w_sum[7:0];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_pix <= '0;
        else       r_pix <= w_pix;
    end

    assign o_pix = r_pix;
endmodule

// File: rtl/inverse_level_shift.sv
// Row-wide inverse level shift: LANES fp32 lanes, valid pipeline and block row counter.
module inverse_level_shift
  import jpeg_dec_pkg::*;
#(
    parameter int LANES = 8,
    parameter int ROWS  = 8
) (
    input logic                  clk,
    input logic                  nrst,
    inverse_level_shift_if.slave bus
);
    localparam int STAGES = 3;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fp32_to_pixel u_lane (
            .clk   (clk),
            .nrst  (nrst),
            .i_din (bus.din[g]),
            .o_pix (bus.dout[g])
        );
    end

    logic [STAGES:1]  r_vld_pipe;
    logic [ROW_W-1:0] r_row;
    logic             w_row_end;

    assign w_row_end = (r_row == ROW_W'(ROWS - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_vld_pipe <= '0;
        else       r_vld_pipe <= {r_vld_pipe[STAGES-1:1], bus.din_valid};
    end

    // Counts rows leaving the pipe, so gaps on the input never disturb block phase
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                    r_row <= '0;
        else if (r_vld_pipe[STAGES])  r_row <= w_row_end ? '0 : r_row + 1'b1;
    end

    assign bus.dout_valid = r_vld_pipe[STAGES];
    assign bus.dout_last  = r_vld_pipe[STAGES] && w_row_end;
endmodule

// File: tb/tb_inverse_level_shift.sv
// Self-checking bench: fixed-vector table, pipeline/counter sequences, random rows vs real-valued model.
module tb_inverse_level_shift;
  localparam int LANES = 8;
  typedef logic [LANES-1:0][31:0] row_t;
  typedef logic [LANES-1:0][7:0]  pix_t;
  typedef struct { logic [31:0] in; logic [7:0] exp; } vec_t;
  typedef struct { pix_t pix; bit last; int due; } exp_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   n_pushed = 0;
  exp_t q[$];
  vec_t tbl[15];

  inverse_level_shift_if #(.LANES(LANES)) bus ();
  inverse_level_shift #(.LANES(LANES), .ROWS(8)) dut (.clk(clk), .nrst(nrst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: decode to real, round half to even, level shift, clamp
  function automatic logic [7:0] ref_pix(input logic [31:0] b);
    int  e, n;
    real mag, fl;
    e = int'(b[30:23]);
    if (e == 255) return (b[22:0] != 0) ? 8'd128 : (b[31] ? 8'd0 : 8'd255);
    if (e == 0) return 8'd128;
    mag = (1.0 + real'(b[22:0]) / 8388608.0) * $pow(2.0, real'(e - 127));
    if (mag >= 256.0) return b[31] ? 8'd0 : 8'd255;
    fl = $floor(mag);
    n  = int'(fl);
    if ((mag - fl > 0.5) || ((mag - fl == 0.5) && (n % 2 == 1))) n++;
    if (b[31]) n = -n;
    n += 128;
    if (n < 0) n = 0;
    if (n > 255) n = 255;
    return 8'(n);
  endfunction

  function automatic pix_t ref_row(input row_t d);
    pix_t p;
    for (int i = 0; i < LANES; i++) p[i] = ref_pix(d[i]);
    return p;
  endfunction

  function automatic logic [31:0] rand_word();
    int mode;
    mode = $urandom_range(0, 3);
    case (mode)
      0:       return $urandom();
      1:       return {1'($urandom()), 8'($urandom_range(120, 134)), 23'($urandom())};
      2:       return {1'($urandom()), 8'($urandom_range(126, 134)), 23'($urandom()) & 23'h7F0000};
      default: return {1'($urandom()), 8'($urandom_range(127, 134)), 23'($urandom()) & 23'h7E0000};
    endcase
  endfunction

  function automatic row_t rand_row();
    row_t d;
    for (int i = 0; i < LANES; i++) d[i] = rand_word();
    return d;
  endfunction

  // Apply one input cycle; valid rows are queued with their due cycle and expected last flag
  task automatic drive(input row_t d, input bit v, input pix_t e);
    exp_t x;
    bus.din       = d;
    bus.din_valid = v;
    if (v) begin
      x.pix  = e;
      x.last = (n_pushed % 8 == 7);
      x.due  = cyc + 3;
      q.push_back(x);
      n_pushed++;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bus.din_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(q.size()), 64'(0));
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #1;
    q.delete();
    n_pushed = 0;
    @(posedge clk); #2;
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin : mon
    exp_t x;
    if (nrst) begin
      if (bus.dout_valid) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_row: got valid at cycle %0d, want no row", cyc);
        end else begin
          x = q.pop_front();
          chk("latency", 64'(cyc), 64'(x.due));
          chk("row_data", 64'(bus.dout), 64'(x.pix));
          chk("row_last", 64'(bus.dout_last), 64'(x.last));
        end
      end else begin
        chk("last_without_valid", 64'(bus.dout_last), 64'(0));
        if (q.size() != 0 && q[0].due <= cyc) begin
          x = q.pop_front();
          tests++; fails++;
          $display("FAIL missing_row: got no valid at cycle %0d, want row due at %0d", cyc, x.due);
        end
      end
    end
  end

  initial begin
    row_t d;
    pix_t e;
    bit   pat[7];
    bus.din       = '0;
    bus.din_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout", 64'(bus.dout), 64'(0));
    chk("reset_valid", 64'(bus.dout_valid), 64'(0));
    chk("reset_last", 64'(bus.dout_last), 64'(0));
    nrst = 1'b1;
    @(posedge clk); #1;

    tbl[0]  = '{32'h00000000, 8'd128};
    tbl[1]  = '{32'hC3000000, 8'd0};
    tbl[2]  = '{32'h42FE0000, 8'd255};
    tbl[3]  = '{32'h3FC00000, 8'd130};
    tbl[4]  = '{32'h40200000, 8'd130};
    tbl[5]  = '{32'h3F000000, 8'd128};
    tbl[6]  = '{32'hBF000000, 8'd128};
    tbl[7]  = '{32'h42FF0000, 8'd255};
    tbl[8]  = '{32'h43960000, 8'd255};
    tbl[9]  = '{32'hC47A0000, 8'd0};
    tbl[10] = '{32'h7F800000, 8'd255};
    tbl[11] = '{32'hFF800000, 8'd0};
    tbl[12] = '{32'h7FC00000, 8'd128};
    tbl[13] = '{32'h00000001, 8'd128};
    tbl[14] = '{32'hC3008000, 8'd0};

    // Whole table, packed 8 entries per row; last row wraps to entry 0
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < LANES; i++) begin
        d[i] = tbl[(r * LANES + i) % 15].in;
        e[i] = tbl[(r * LANES + i) % 15].exp;
      end
      drive(d, 1'b1, e);
    end
    // Each table entry broadcast on all lanes
    for (int t = 0; t < 15; t++) begin
      for (int i = 0; i < LANES; i++) begin
        d[i] = tbl[t].in;
        e[i] = tbl[t].exp;
      end
      drive(d, 1'b1, e);
    end
    drain();

    do_reset();
    for (int r = 0; r < 16; r++) begin
      d = rand_row();
      drive(d, 1'b1, ref_row(d));
    end
    drain();

    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int rep = 0; rep < 2; rep++)
      for (int i = 0; i < 7; i++) begin
        d = rand_row();
        drive(d, pat[i], ref_row(d));
      end
    drain();

    for (int r = 0; r < 5; r++) begin
      d = rand_row();
      drive(d, 1'b1, ref_row(d));
    end
    bus.din_valid = 1'b0;
    @(posedge clk); #3;
    chk("pre_reset_valid", 64'(bus.dout_valid), 64'(1));
    nrst = 1'b0;
    #1;
    chk("async_reset_valid", 64'(bus.dout_valid), 64'(0));
    chk("async_reset_last", 64'(bus.dout_last), 64'(0));
    chk("async_reset_dout", 64'(bus.dout), 64'(0));
    q.delete();
    n_pushed = 0;
    @(posedge clk); #2;
    nrst = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 8; r++) begin
      d = rand_row();
      drive(d, 1'b1, ref_row(d));
    end
    drain();

    for (int r = 0; r < 10000; r++) begin
      d = rand_row();
      drive(d, ($urandom_range(0, 9) != 0), ref_row(d));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
